// File: rtl/soc_system_sample_fifo.sv
// soc_system_sample_fifo: show-ahead synchronous sample FIFO with occupancy count.
// The head word is presented on out_data whenever out_valid is high and is popped
// by out_ready. The occupancy count (usedw) feeds a PIO input port.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (release synchronised externally)
//   clear      synchronous flush, beats any concurrent read or write
//   in_data    write payload            in_valid  write request
//   in_ready   FIFO not full            out_data  head-of-FIFO word
//   out_valid  FIFO not empty           out_ready consumer pops head word
//   usedw      occupied word count, zero-extended to 32 bits
//   overflow   sticky: a write was refused while full
module soc_system_sample_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           usedw,
   output logic                  overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  wr_en_c;
   logic                  rd_en_c;

   // Acceptance: handshakes only against registered flags, so a pop never frees
   // a slot for a write in the same cycle, and a write is never bypassed to the
   // read side while empty.
   always_comb begin
      wr_en_c     = in_valid & in_ready_q & ~clear;
      rd_en_c     = out_valid_q & out_ready & ~clear;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (in_valid & ~in_ready_q);

      if (wr_en_c) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (rd_en_c) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({wr_en_c, rd_en_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end

      in_ready_d  = (count_d != CNT_W'(DEPTH));
      out_valid_d = (count_d != '0);
   end

   // Control state; reset empties the FIFO immediately without a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage array, intentionally not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

   // Show-ahead: read address is the registered read pointer.
   assign out_data  = mem[rd_ptr_q];
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;
   assign usedw     = 32'(count_q);

endmodule

// File: tb/tb_soc_system_sample_fifo.sv
// tb_soc_system_sample_fifo: directed checks of the sample FIFO, plus a small
// queue model for the long push/pop sequences.
module tb_soc_system_sample_fifo;

   localparam int unsigned DEPTH = 256;

   logic        clk;
   logic        reset_n;
   logic        clear;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] usedw;
   logic        overflow;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] q[$];
   int unsigned cnt = 0;
   logic        ovf = 1'b0;

   soc_system_sample_fifo dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .usedw     (usedw),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock with the given stimulus, checked against the queue model.
   task automatic cyc(input logic wv, input logic [31:0] wd, input logic rr);
      logic w;
      logic r;
      w = wv && (cnt < DEPTH);
      r = rr && (cnt > 0);
      in_valid  = wv;
      in_data   = wd;
      out_ready = rr;
      if (r) check_eq("pop_data", out_data, q[0]);
      step();
      if (wv && cnt == DEPTH) ovf = 1'b1;
      if (r) begin
         void'(q.pop_front());
         cnt--;
      end
      if (w) begin
         q.push_back(wd);
         cnt++;
      end
      check_eq("usedw", usedw, cnt);
      check_eq("out_valid", 32'(out_valid), 32'(cnt != 0));
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic model_flush();
      q.delete();
      cnt = 0;
      ovf = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      model_flush();
   endtask

   initial begin
      reset_n   = 1'b0;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_usedw", usedw, 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;

      // Basic write/read, hand-computed values.
      in_valid = 1'b1;
      in_data  = 32'h11;
      step();
      check_eq("wr1_usedw", usedw, 32'd1);
      check_eq("wr1_out_valid", 32'(out_valid), 32'd1);
      check_eq("wr1_out_data", out_data, 32'h11);
      in_data = 32'h22;
      step();
      check_eq("wr2_usedw", usedw, 32'd2);
      in_data = 32'h33;
      step();
      check_eq("wr3_usedw", usedw, 32'd3);
      in_valid = 1'b0;
      check_eq("head_11", out_data, 32'h11);
      out_ready = 1'b1;
      step();
      check_eq("head_22", out_data, 32'h22);
      step();
      check_eq("head_33", out_data, 32'h33);
      step();
      check_eq("drained_out_valid", 32'(out_valid), 32'd0);
      check_eq("drained_usedw", usedw, 32'd0);
      out_ready = 1'b0;

      // Fill, overflow, drain.
      for (int i = 0; i < 256; i++) cyc(1'b1, 32'(i), 1'b0);
      check_eq("full_usedw", usedw, 32'd256);
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      cyc(1'b1, 32'hDEAD, 1'b0);
      check_eq("ovf_set", 32'(overflow), 32'd1);
      check_eq("ovf_usedw", usedw, 32'd256);
      for (int i = 0; i < 256; i++) cyc(1'b0, 32'd0, 1'b1);
      check_eq("ovf_sticky", 32'(overflow), 32'(ovf));
      pulse_clear();
      check_eq("clr_ovf", 32'(overflow), 32'd0);

      // Simultaneous push/pop at 5, at full, at empty.
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'(100 + i), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'(105 + i), 1'b1);
      check_eq("sim5_usedw", usedw, 32'd5);
      for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 256; i++) cyc(1'b1, 32'(i), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'(1000 + i), 1'b1);
      check_eq("simfull_usedw", usedw, 32'd255);
      for (int i = 0; i < 255; i++) cyc(1'b0, 32'd0, 1'b1);
      check_eq("simfull_drained", usedw, 32'd0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'(2000 + i), 1'b1);
      check_eq("simempty_usedw", usedw, 32'd1);
      check_eq("simempty_head", out_data, 32'(2009));

      // Random push/pop across pointer wrap.
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 50));
      end
      check_eq("rand_overflow", 32'(overflow), 32'(ovf));

      // Clear at usedw=40 with overflow set, while a write is presented.
      pulse_clear();
      for (int i = 0; i < 256; i++) cyc(1'b1, 32'(3000 + i), 1'b0);
      cyc(1'b1, 32'hBAD, 1'b0);
      for (int i = 0; i < 216; i++) cyc(1'b0, 32'd0, 1'b1);
      check_eq("pre_clr_usedw", usedw, 32'd40);
      check_eq("pre_clr_ovf", 32'(overflow), 32'd1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hBEEF;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      model_flush();
      check_eq("clr_usedw", usedw, 32'd0);
      check_eq("clr_overflow", 32'(overflow), 32'd0);
      check_eq("clr_out_valid", 32'(out_valid), 32'd0);
      check_eq("clr_in_ready", 32'(in_ready), 32'd1);
      cyc(1'b1, 32'h77, 1'b0);
      check_eq("post_clr_head", out_data, 32'h77);

      // Asynchronous reset between edges at usedw=17.
      for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0);
      check_eq("pre_rst_usedw", usedw, 32'd17);
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("arst_usedw", usedw, 32'd0);
      check_eq("arst_out_valid", 32'(out_valid), 32'd0);
      check_eq("arst_in_ready", 32'(in_ready), 32'd1);
      #2;
      reset_n  = 1'b1;
      model_flush();
      in_valid = 1'b1;
      in_data  = 32'hA5;
      step();
      in_valid = 1'b0;
      check_eq("post_rst_data", out_data, 32'hA5);
      check_eq("post_rst_usedw", usedw, 32'd1);
      check_eq("post_rst_out_valid", 32'(out_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
